// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, constants and the key-code map for the 4x3
// phone-style keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD} state_t;

    localparam logic [3:0] KEY_NONE = 4'h0;
    localparam logic [3:0] KEY_ZERO = 4'hA;
    localparam logic [3:0] KEY_STAR = 4'hB;
    localparam logic [3:0] KEY_HASH = 4'hC;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 3;

    // Rows 0-2 are the digits 1-9 laid out row-major; row 3 is * 0 #.
    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        if (row == 2'd3) begin
            case (col)
                2'd0:    key_map = KEY_STAR;
                2'd1:    key_map = KEY_ZERO;
                default: key_map = KEY_HASH;
            endcase
        end else begin
            key_map = {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
        end
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// keypad_sync: WIDTH-bit two-flop synchronizer with synchronous active-high
// reset.
//   clk, rst : clock / synchronous reset
//   d        : asynchronous input
//   q        : synchronized output (RST_VAL while in reset)
module keypad_sync #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4-row x 3-column matrix keypad, debounces press
// and release, and emits one 4-bit key code per confirmed press.
//   clk, rst   : clock / synchronous active-high reset
//   row_in     : keypad rows, active-low, asynchronous
//   col_out    : one-hot active-low column drive
//   key_code   : last confirmed key code, held until the next strobe
//   key_strobe : one-cycle pulse per confirmed press (or repeat)
//   keypad_out : key_code during key_strobe, KEY_NONE otherwise
//   key_held   : high from the strobe until the release is confirmed
// Build option KEYPAD_REPEAT_EN: re-strobe every REPEAT_CYC cycles while
// the key stays down.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CYC = 100000,
    parameter int REPEAT_CYC   = 5000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_ROWS-1:0] row_in,
    output logic [NUM_COLS-1:0] col_out,
    output logic [3:0]          key_code,
    output logic                key_strobe,
    output logic [3:0]          keypad_out,
    output logic                key_held
);

    localparam int DIV_W = $clog2(SCAN_DIV + 1);
    localparam int DEB_W = $clog2(DEBOUNCE_CYC + 1);

    if (SCAN_DIV < 4 || DEBOUNCE_CYC < 2 || REPEAT_CYC < 1) begin : g_param_chk
        $error("keypad_scanner: parameter out of range");
    end

    logic [NUM_ROWS-1:0] row_s;

    keypad_sync #(.WIDTH(NUM_ROWS), .RST_VAL({NUM_ROWS{1'b1}})) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (row_in),
        .q   (row_s)
    );

    state_t              state, state_n;
    logic [1:0]          col_idx, col_n, col_nxt;
    logic [DIV_W-1:0]    div_cnt, div_n;
    logic [DEB_W-1:0]    deb_cnt, deb_n;   // press count in DEBOUNCE, release count in HOLD
    logic [NUM_ROWS-1:0] lat_pat, pat_n;
    logic [3:0]          lat_code, lcode_n;
    logic [3:0]          code_n;
    logic                strobe_n, held_n;

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYC + 1);
    logic [REP_W-1:0]    rep_cnt, rep_n;
`endif

    // Single-low-row detection; more than one low row is treated as ghosting.
    logic [NUM_ROWS-1:0] row_low;
    logic                one_low;
    logic [1:0]          row_idx;

    always_comb begin
        row_low = ~row_s;
        one_low = (row_low != '0) && ((row_low & (row_low - 1'b1)) == '0);
        row_idx = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (row_low[r]) row_idx = 2'(r);
        end
    end

    assign col_nxt    = (col_idx == 2'(NUM_COLS - 1)) ? 2'd0 : col_idx + 2'd1;
    assign col_out    = ~(3'b001 << col_idx);
    assign keypad_out = key_strobe ? key_code : KEY_NONE;

    always_comb begin
        state_n  = state;
        col_n    = col_idx;
        div_n    = div_cnt;
        deb_n    = deb_cnt;
        pat_n    = lat_pat;
        lcode_n  = lat_code;
        code_n   = key_code;
        strobe_n = 1'b0;
        held_n   = key_held;
`ifdef KEYPAD_REPEAT_EN
        rep_n    = rep_cnt;
`endif
        case (state)
            SCAN: begin
                if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
                    div_n = '0;
                    deb_n = '0;
                    if (one_low) begin
                        pat_n   = row_s;
                        lcode_n = key_map(row_idx, col_idx);
                        state_n = DEBOUNCE;
                    end else begin
                        col_n = col_nxt;
                    end
                end else begin
                    div_n = div_cnt + DIV_W'(1);
                end
            end
            DEBOUNCE: begin
                if (row_s == lat_pat) begin
                    if (deb_cnt == DEB_W'(DEBOUNCE_CYC - 1)) begin
                        strobe_n = 1'b1;
                        code_n   = lat_code;
                        held_n   = 1'b1;
                        deb_n    = '0;
                        state_n  = HOLD;
`ifdef KEYPAD_REPEAT_EN
                        rep_n    = '0;
`endif
                    end else begin
                        deb_n = deb_cnt + DEB_W'(1);
                    end
                end else begin
                    state_n = SCAN;
                    col_n   = col_nxt;
                    div_n   = '0;
                    deb_n   = '0;
                end
            end
            HOLD: begin
`ifdef KEYPAD_REPEAT_EN
                // Period keeps running during a bouncy release, but only a
                // still-matching key re-strobes.
                if (rep_cnt == REP_W'(REPEAT_CYC - 1)) begin
                    rep_n    = '0;
                    strobe_n = (row_s == lat_pat);
                end else begin
                    rep_n = rep_cnt + REP_W'(1);
                end
`endif
                if (row_s == '1) begin
                    if (deb_cnt == DEB_W'(DEBOUNCE_CYC - 1)) begin
                        held_n  = 1'b0;
                        state_n = SCAN;
                        col_n   = col_nxt;
                        div_n   = '0;
                        deb_n   = '0;
`ifdef KEYPAD_REPEAT_EN
                        rep_n   = '0;
`endif
                    end else begin
                        deb_n = deb_cnt + DEB_W'(1);
                    end
                end else begin
                    deb_n = '0;
                end
            end
            default: begin
                state_n = SCAN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SCAN;
            col_idx    <= '0;
            div_cnt    <= '0;
            deb_cnt    <= '0;
            lat_pat    <= '1;
            lat_code   <= KEY_NONE;
            key_code   <= KEY_NONE;
            key_strobe <= 1'b0;
            key_held   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt    <= '0;
`endif
        end else begin
            state      <= state_n;
            col_idx    <= col_n;
            div_cnt    <= div_n;
            deb_cnt    <= deb_n;
            lat_pat    <= pat_n;
            lat_code   <= lcode_n;
            key_code   <= code_n;
            key_strobe <= strobe_n;
            key_held   <= held_n;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt    <= rep_n;
`endif
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: scoreboard bench for keypad_scanner. A matrix model
// turns pressed keys plus col_out into row_in; expected key codes are queued
// when a press is driven and popped by the strobe monitor.
module tb_keypad_scanner;
    import keypad_pkg::*;

    localparam int SD = 4;
    localparam int DC = 8;
    localparam int RC = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row_in;
    logic [2:0] col_out;
    logic [3:0] key_code, keypad_out;
    logic       key_strobe, key_held;

    logic [3:0][2:0] pressed = '0;
    logic            ovr_en  = 1'b1;
    logic [3:0]      ovr_val = 4'b0000;

    always #5 clk = ~clk;

    // Pressed key (r,c) pulls row r low while column c is driven.
    always_comb begin
        row_in = '1;
        for (int r = 0; r < 4; r++) begin
            row_in[r] = ~|(pressed[r] & ~col_out);
        end
        if (ovr_en) row_in = ovr_val;
    end

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CYC(DC), .REPEAT_CYC(RC)) dut (
        .clk        (clk),
        .rst        (rst),
        .row_in     (row_in),
        .col_out    (col_out),
        .key_code   (key_code),
        .key_strobe (key_strobe),
        .keypad_out (keypad_out),
        .key_held   (key_held)
    );

    int         n_chk = 0;
    int         n_pass = 0;
    int         cyc = 0;
    logic [3:0] exp_q[$];
    int         stb_cyc[$];
    logic       prev_stb = 1'b0;
    logic [3:0] mon_exp;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_sb(input string tag, input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic wait_col(input logic [2:0] c, input int budget);
        int k = 0;
        while (col_out !== c && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (k == budget) chk("wait_col_timeout", col_out, c);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (key_strobe === 1'b1) begin
            chk("strobe_gap", prev_stb, 0);
            stb_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", key_code, KEY_NONE);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("keypad_out", keypad_out, mon_exp);
                chk("key_code", key_code, mon_exp);
                chk("held_at_strobe", key_held, 1);
            end
        end else begin
            chk("keypad_out_idle", keypad_out, 0);
        end
        prev_stb = key_strobe;
    end

    initial begin
        int k;
        logic [2:0] seen;

        // Reset with all rows low.
        repeat (3) begin
            @(negedge clk);
            chk("rst_col", col_out, 3'b110);
            chk("rst_strobe", key_strobe, 0);
            chk("rst_held", key_held, 0);
            chk("rst_code", key_code, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_col", col_out, 3'b110);
        chk("post_rst_strobe", key_strobe, 0);
        chk("post_rst_held", key_held, 0);
        ovr_en = 1'b0;
        tick(20);

        // Clean press of '3', held 30 cycles.
        stb_cyc.delete();
        exp_q.push_back(4'h3);
        pressed[0][2] = 1'b1;
        tick(30);
        chk("press3_strobe", exp_q.size(), 0);
        exp_q.delete();
        pressed[0][2] = 1'b0;
        tick(DC + 1);
        chk("press3_held_before", key_held, 1);
        tick(1);
        chk("press3_held_fall", key_held, 0);
        chk("press3_code_hold", key_code, 4'h3);
        chk("press3_one_strobe", stb_cyc.size(), 1);
        tick(10);

        // Bounce: row1 low 5 cycles under col0 starting at slot start.
        wait_col(3'b011, 4 * SD);
        wait_col(3'b110, 4 * SD);
        pressed[1][0] = 1'b1;
        tick(5);
        pressed[1][0] = 1'b0;
        tick(2);
        chk("bounce_frozen", col_out, 3'b110);
        tick(1);
        chk("bounce_resume", col_out, 3'b101);
        chk("bounce_held", key_held, 0);
        tick(20);

        // Ghost: rows 0 and 2 under col1.
        pressed[0][1] = 1'b1;
        pressed[2][1] = 1'b1;
        seen = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (col_out == 3'b110) seen[0] = 1'b1;
            if (col_out == 3'b101) seen[1] = 1'b1;
            if (col_out == 3'b011) seen[2] = 1'b1;
        end
        chk("ghost_rotate", seen, 3'b111);
        chk("ghost_held", key_held, 0);
        pressed = '0;
        tick(10);

        // Reset mid-HOLD on '1', key stays down, rescan must re-strobe.
        exp_q.push_back(4'h1);
        pressed[0][0] = 1'b1;
        wait_sb("press1_strobe", 40);
        tick(2);
        chk("press1_held", key_held, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_code", key_code, 0);
        chk("midrst_held", key_held, 0);
        chk("midrst_col", col_out, 3'b110);
        exp_q.push_back(4'h1);
        rst = 1'b0;
        wait_sb("rescan_strobe", 40);
        pressed[0][0] = 1'b0;
        k = 0;
        while (key_held !== 1'b0 && k < 2 * DC + 4) begin
            @(negedge clk);
            k++;
        end
        chk("press1_release", key_held, 0);
        tick(10);

`ifdef KEYPAD_REPEAT_EN
        // Hold '#': strobes at press, +RC, +2*RC, none after release.
        stb_cyc.delete();
        exp_q.push_back(KEY_HASH);
        pressed[3][2] = 1'b1;
        wait_sb("hash_strobe", 40);
        exp_q.push_back(KEY_HASH);
        exp_q.push_back(KEY_HASH);
        tick(2 * RC + 5);
        pressed[3][2] = 1'b0;
        tick(RC + 3 * DC);
        chk("rep_count", stb_cyc.size(), 3);
        chk("rep_queue", exp_q.size(), 0);
        if (stb_cyc.size() >= 3) begin
            chk("rep_gap1", stb_cyc[1] - stb_cyc[0], RC);
            chk("rep_gap2", stb_cyc[2] - stb_cyc[0], 2 * RC);
        end
        chk("rep_held_off", key_held, 0);
`endif

        chk("final_queue", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
